// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - Wishbone claim/EOI interrupt arbiter with fixed or round-robin priority
//
// Purpose:
//   Picks one pending source from the masked interrupt status vector, raises
//   o_irq for it, and lets software claim it with a single read and retire it
//   with a single end-of-interrupt write.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   i_wb_*        Wishbone slave request (adr decoded on [15:0]; sel and cyc unused)
//   o_wb_dat      read data, 32-bit word replicated across the bus width
//   o_wb_ack      write ack is combinational, read ack is one cycle after stb
//   o_wb_err      always 0
//   i_int_status  level-sensitive masked interrupt status, one bit per source
//   o_irq         interrupt request to the core, high while a source is pending
//
// Registers (byte offsets on adr[15:0]):
//   0x00 CLAIM  R   {valid, 26'd0, vector}
//   0x04 EOI    W   vector in data[4:0]
//   0x08 STATUS R   {15'd0, eoi_err, 6'd0, state, 3'd0, rr_ptr}; read clears eoi_err
//   0x0C MODE   RW  bit0: 0 = fixed priority, 1 = round-robin
module interrupt_arbiter #(
  parameter int WB_DWIDTH = 128,
  parameter int WB_SWIDTH = 16,
  parameter int N_SRC     = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  input  logic [N_SRC-1:0]     i_int_status,
  output logic                 o_irq
);

  localparam logic [15:0] ADR_CLAIM  = 16'h0000;
  localparam logic [15:0] ADR_EOI    = 16'h0004;
  localparam logic [15:0] ADR_STATUS = 16'h0008;
  localparam logic [15:0] ADR_MODE   = 16'h000C;
  localparam logic [31:0] RD_DEFAULT = 32'h2233_4455;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PENDING    = 2'd1,
    S_IN_SERVICE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_vec_q, cur_vec_d;
  logic [4:0]  rr_ptr_q, rr_ptr_d;
  logic        mode_q, mode_d;
  logic        eoi_err_q, eoi_err_d;
  logic        irq_q, irq_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic [15:0] adr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;

  assign adr = i_wb_adr[15:0];

  // ack_q doubles as "read ack pending": no new transfer is taken while it is set.
  assign rd_en = i_wb_stb & ~i_wb_we & ~ack_q;
  assign wr_en = i_wb_stb &  i_wb_we & ~ack_q;

  // On the wide bus the write word sits in the lane named by adr[3:2].
  if (WB_DWIDTH == 128) begin : g_lane128
    assign wdata = i_wb_dat[{i_wb_adr[3:2], 5'd0} +: 32];
  end else begin : g_lane32
    assign wdata = i_wb_dat[31:0];
  end

  // Arbitration: rotate the status so the search start lands at bit 0, then the
  // lowest set bit of the rotated vector is the winner (offset from the start).
  logic [4:0]       arb_start;
  logic [N_SRC-1:0] rot;
  logic [4:0]       winner;
  logic             cur_pending;
  logic [4:0]       rr_next;

  always_comb begin
    arb_start = mode_q ? rr_ptr_q : 5'd0;
    rot       = N_SRC'({i_int_status, i_int_status} >> arb_start);
    winner    = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        if (int'(arb_start) + i >= N_SRC) winner = 5'(int'(arb_start) + i - N_SRC);
        else                              winner = 5'(int'(arb_start) + i);
      end
    end

    cur_pending = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (5'(i) == cur_vec_q) cur_pending = i_int_status[i];
    end

    rr_next = (int'(cur_vec_q) + 1 == N_SRC) ? 5'd0 : cur_vec_q + 5'd1;
  end

  logic claim;
  logic eoi_wr;
  logic eoi_ok;

  assign claim  = rd_en & (adr == ADR_CLAIM) & (state_q == S_PENDING);
  assign eoi_wr = wr_en & (adr == ADR_EOI);
  assign eoi_ok = eoi_wr & (state_q == S_IN_SERVICE) & (wdata[4:0] == cur_vec_q);

  always_comb begin
    state_d   = state_q;
    cur_vec_d = cur_vec_q;
    rr_ptr_d  = rr_ptr_q;
    mode_d    = mode_q;
    eoi_err_d = eoi_err_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;

    if (rd_en) begin
      ack_d = 1'b1;
      case (adr)
        ADR_CLAIM: begin
          // Valid in PENDING (the claim itself) and IN_SERVICE (idempotent re-read).
          if (state_q == S_PENDING || state_q == S_IN_SERVICE)
            rdata_d = {1'b1, 26'd0, cur_vec_q};
          else
            rdata_d = 32'd0;
        end
        ADR_STATUS: begin
          rdata_d   = {15'd0, eoi_err_q, 6'd0, state_q, 3'd0, rr_ptr_q};
          eoi_err_d = 1'b0;
        end
        ADR_MODE: rdata_d = {31'd0, mode_q};
        default:  rdata_d = RD_DEFAULT;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (|i_int_status) begin
          cur_vec_d = winner;
          state_d   = S_PENDING;
        end
      end
      S_PENDING: begin
        // A claim in the same cycle as the source dropping still succeeds.
        if (claim)             state_d = S_IN_SERVICE;
        else if (!cur_pending) state_d = S_IDLE;
      end
      S_IN_SERVICE: begin
        if (eoi_ok) begin
          state_d = S_IDLE;
          if (mode_q) rr_ptr_d = rr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Placed after the STATUS-read clear so a simultaneous set wins.
    if (eoi_wr && !eoi_ok) eoi_err_d = 1'b1;

    if (wr_en && adr == ADR_MODE) mode_d = wdata[0];
  end

  assign irq_d = (state_d == S_PENDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_vec_q <= 5'd0;
      rr_ptr_q  <= 5'd0;
      mode_q    <= 1'b0;
      eoi_err_q <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cur_vec_q <= cur_vec_d;
      rr_ptr_q  <= rr_ptr_d;
      mode_q    <= mode_d;
      eoi_err_q <= eoi_err_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_irq    = irq_q;
  assign o_wb_ack = ack_q | (wr_en & ~reset);
  assign o_wb_err = 1'b0;
  assign o_wb_dat = {(WB_DWIDTH / 32){rdata_q}};

  logic unused_ok;
  assign unused_ok = ^{i_wb_sel, i_wb_cyc, i_wb_adr[31:16], wdata[31:5]};

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - self-checking bench for interrupt_arbiter
module tb_interrupt_arbiter;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int N  = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   adr;
  logic [SW-1:0] sel;
  logic          we;
  logic [DW-1:0] dat;
  logic [DW-1:0] rdat;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;
  logic [N-1:0]  status;
  logic          irq;

  int checks_total = 0;
  int checks_pass  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  interrupt_arbiter #(.WB_DWIDTH(DW), .WB_SWIDTH(SW), .N_SRC(N)) dut (
    .clk(clk), .reset(reset),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(dat),
    .o_wb_dat(rdat), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_ack(ack), .o_wb_err(err),
    .i_int_status(status), .o_irq(irq)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_state, m_vec, m_rr, m_mode, m_err;
  logic [31:0] m_rdata;
  logic        m_rack;

  function automatic int pick(input logic [N-1:0] s, input int start);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      int j;
      j  = (start + k) % N;
      sh = s >> j;
      if (sh[0]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic rd, wr, claim, good, eoi;
    logic [127:0] sh;
    logic [N-1:0] ss;
    logic [31:0] wd;
    int a, ns;
    if (reset) begin
      m_state = 0; m_vec = 0; m_rr = 0; m_mode = 0; m_err = 0;
      m_rdata = 0; m_rack = 0;
    end else begin
      a  = int'(adr[15:0]);
      rd = stb && !we && !m_rack;
      wr = stb && we && !m_rack;
      sh = dat >> (32 * adr[3:2]);
      wd = sh[31:0];
      claim = rd && a == 0 && m_state == 1;
      eoi   = wr && a == 4;
      good  = eoi && m_state == 2 && int'(wd[4:0]) == m_vec;
      if (rd) begin
        case (a)
          0:       m_rdata = (m_state != 0) ? (32'h8000_0000 | 32'(m_vec)) : 32'd0;
          8: begin
            m_rdata = 32'((m_err << 16) | (m_state << 8) | m_rr);
            m_err   = 0;
          end
          12:      m_rdata = 32'(m_mode);
          default: m_rdata = 32'h2233_4455;
        endcase
      end
      ns = m_state;
      if (m_state == 0) begin
        if (status != 0) begin
          m_vec = pick(status, m_mode ? m_rr : 0);
          ns = 1;
        end
      end else if (m_state == 1) begin
        ss = status >> m_vec;
        if (claim) ns = 2;
        else if (!ss[0]) ns = 0;
      end else if (good) begin
        ns = 0;
        if (m_mode != 0) m_rr = (m_vec + 1) % N;
      end
      m_state = ns;
      if (eoi && !good) m_err = 1;
      if (wr && a == 12) m_mode = int'(wd[0]);
      m_rack = rd;
    end
  end

  // One compare process, sampling just before each rising edge.
  always begin : compare
    logic exp_ack;
    @(negedge clk);
    #4;
    if (chk_en) begin
      check("cyc_irq", irq, m_state == 1);
      exp_ack = m_rack || (stb && we && !m_rack && !reset);
      check("cyc_ack", ack, exp_ack);
      check("cyc_err", err, 1'b0);
      if (m_rack) check("cyc_rdata", rdat, {4{m_rdata}});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_write(input logic [15:0] a, input logic [31:0] d);
    logic [127:0] w;
    w = {4{~d}};
    w[32*a[3:2] +: 32] = d;
    @(negedge clk);
    adr = {16'h0, a}; we = 1'b1; stb = 1'b1; dat = w;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; dat = '0;
  endtask

  task automatic wb_read(input logic [15:0] a, input bit drop, output logic [127:0] d);
    int n;
    @(negedge clk);
    adr = {16'h0, a}; we = 1'b0; stb = 1'b1;
    if (drop) status = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) check("read_ack_timeout", 1'b0, 1'b1);
    d = rdat;
    stb = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [127:0] d;
    wb_read(a, 1'b0, d);
    check(name, d[31:0], exp);
  endtask

  task automatic wait_irq(input string name);
    int n;
    n = 0;
    while (!irq && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, irq, 1'b1);
  endtask

  int rr_vecs[5] = '{1, 5, 6, 7, 8};

  initial begin : stim
    logic [127:0] d;
    reset = 1'b1; adr = '0; sel = '1; we = 1'b0; dat = '0; cyc = 1'b1; stb = 1'b0; status = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // reset defaults
    rd_check("rst_status", 16'h08, 32'h0);
    rd_check("rst_mode", 16'h0C, 32'h0);
    check("rst_irq", irq, 1'b0);

    // fixed priority, lowest index wins
    status = 9'h0A0;
    @(negedge clk);
    check("fix_irq_latency", irq, 1'b1);
    rd_check("fix_claim", 16'h00, 32'h8000_0005);
    rd_check("fix_reclaim_idem", 16'h00, 32'h8000_0005);
    wb_write(16'h04, 32'd5);
    wait_irq("fix_irq_again");
    rd_check("fix_claim2", 16'h00, 32'h8000_0005);
    status = '0;
    wb_write(16'h04, 32'd5);

    // round-robin
    wb_write(16'h0C, 32'd1);
    rd_check("rr_mode_rd", 16'h0C, 32'd1);
    status = 9'h1E2;
    foreach (rr_vecs[i]) begin
      wait_irq("rr_irq");
      rd_check("rr_claim", 16'h00, 32'h8000_0000 | 32'(rr_vecs[i]));
      wb_write(16'h04, 32'(rr_vecs[i]));
    end
    rd_check("rr_ptr_wrap", 16'h08, 32'h0000_0100);
    wait_irq("rr_irq_wrap");
    rd_check("rr_claim_wrap", 16'h00, 32'h8000_0001);
    status = '0;
    wb_write(16'h04, 32'd1);
    wb_write(16'h0C, 32'd0);

    // retraction before claim
    status = 9'h002;
    wait_irq("ret_irq");
    status = '0;
    @(negedge clk);
    check("ret_irq_drop", irq, 1'b0);
    rd_check("ret_status", 16'h08, 32'h0000_0002);
    rd_check("ret_claim_idle", 16'h00, 32'h0);

    // claim and retraction in the same cycle: claim wins
    status = 9'h002;
    wait_irq("race_irq");
    wb_read(16'h00, 1'b1, d);
    check("race_claim", d[31:0], 32'h8000_0001);
    rd_check("race_status", 16'h08, 32'h0000_0202);
    wb_write(16'h04, 32'd1);
    rd_check("race_eoi_ok", 16'h08, 32'h0000_0002);

    // bad EOI
    status = 9'h002;
    wait_irq("bad_irq");
    rd_check("bad_claim", 16'h00, 32'h8000_0001);
    wb_write(16'h04, 32'd3);
    rd_check("bad_err_set", 16'h08, 32'h0001_0202);
    rd_check("bad_err_clr", 16'h08, 32'h0000_0202);
    status = '0;
    wb_write(16'h04, 32'd1);
    wb_write(16'h04, 32'd4);
    rd_check("idle_eoi_err", 16'h08, 32'h0001_0002);

    // unmapped read and lane select
    wb_read(16'h40, 1'b0, d);
    check("unmapped_lanes", d, {4{32'h2233_4455}});
    status = 9'h100;
    wait_irq("lane_irq");
    rd_check("lane_claim", 16'h00, 32'h8000_0008);
    status = '0;
    wb_write(16'h04, 32'd8);
    rd_check("lane_eoi_ok", 16'h08, 32'h0000_0002);

    // reset mid-service
    wb_write(16'h0C, 32'd1);
    status = 9'h004;
    wait_irq("rst_mid_irq");
    rd_check("rst_mid_claim", 16'h00, 32'h8000_0002);
    reset = 1'b1;
    @(negedge clk);
    status = '0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_irq_low", irq, 1'b0);
    rd_check("rst_mid_status", 16'h08, 32'h0);
    rd_check("rst_mid_mode", 16'h0C, 32'h0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
